// File: rtl/fetch_pkg.sv
// Shared fetch-queue definitions: default widths/depth and the stored bundle layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN, PHT_ADDRESS and FQ_DEPTH defaults, plus fq_entry_t, the packed record for one
// two-slot fetch bundle.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int PHT_ADDRESS = 9;
  localparam int FQ_DEPTH    = 8;

  // One fetch bundle. Slot 2 sits at pc+4; its PC is not stored because decode can rebuild it.
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [31:0]            instr1;
    logic [31:0]            instr2;
    logic                   slot_valid1;
    logic                   slot_valid2;
    logic                   pred_taken1;
    logic                   pred_taken2;
    logic [XLEN-1:0]        pred_target1;
    logic [XLEN-1:0]        pred_target2;
    logic [PHT_ADDRESS-1:0] pht_index1;
    logic [PHT_ADDRESS-1:0] pht_index2;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling queue between the branch-predict stage and decode, holding two-slot fetch bundles.
// Latency: an enqueue becomes visible at the head one cycle later; there is no same-cycle pass-through.
// Backpressure: enq_ready comes only from the registered count, so a full queue refuses input even while dequeuing.
// Ports:
//   CLK, reset      - single clock; synchronous active-high reset.
//   flush           - drops every queued bundle and wins over both handshakes.
//   enq_*           - incoming bundle with per-slot prediction info; valid/ready handshake.
//   deq_*           - head bundle with first-word fall-through; all fields read 0 while deq_valid is low.
//   fq_count        - number of occupied entries.
// The struct field widths come from fetch_pkg, so the XLEN and PHT_ADDRESS overrides must match the package.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN        = fetch_pkg::XLEN,
  parameter int PHT_ADDRESS = fetch_pkg::PHT_ADDRESS,
  parameter int FQ_DEPTH    = fetch_pkg::FQ_DEPTH
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         flush,

  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [XLEN-1:0]              enq_pc,
  input  logic [31:0]                  enq_instr1,
  input  logic [31:0]                  enq_instr2,
  input  logic                         enq_btb_hit1,
  input  logic                         enq_btb_hit2,
  input  logic                         enq_pred_taken1,
  input  logic                         enq_pred_taken2,
  input  logic [XLEN-1:0]              enq_pred_target1,
  input  logic [XLEN-1:0]              enq_pred_target2,
  input  logic [PHT_ADDRESS-1:0]       enq_pht_index1,
  input  logic [PHT_ADDRESS-1:0]       enq_pht_index2,

  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [XLEN-1:0]              deq_pc,
  output logic [31:0]                  deq_instr1,
  output logic [31:0]                  deq_instr2,
  output logic [XLEN-1:0]              deq_pred_target1,
  output logic [XLEN-1:0]              deq_pred_target2,
  output logic [PHT_ADDRESS-1:0]       deq_pht_index1,
  output logic [PHT_ADDRESS-1:0]       deq_pht_index2,
  output logic                         deq_slot_valid1,
  output logic                         deq_slot_valid2,
  output logic                         deq_pred_taken1,
  output logic                         deq_pred_taken2,

  output logic [$clog2(FQ_DEPTH):0]    fq_count
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Bundle storage. It has no reset: an entry is only read after it has been written.
  fq_entry_t mem_q [FQ_DEPTH];

  fq_entry_t wr_entry;
  fq_entry_t head_entry;
  logic      enq_fire;
  logic      deq_fire;

  assign enq_ready = (count_q < CNT_W'(FQ_DEPTH));
  assign deq_valid = (count_q != '0);
  assign fq_count  = count_q;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  // A prediction only counts as taken when the BTB also hit. A taken slot 1 redirects fetch,
  // so slot 2 of that bundle is on the wrong path and is marked invalid.
  always_comb begin
    wr_entry              = '0;
    wr_entry.pc           = enq_pc;
    wr_entry.instr1       = enq_instr1;
    wr_entry.instr2       = enq_instr2;
    wr_entry.pred_taken1  = enq_btb_hit1 & enq_pred_taken1;
    wr_entry.pred_taken2  = enq_btb_hit2 & enq_pred_taken2;
    wr_entry.slot_valid1  = 1'b1;
    wr_entry.slot_valid2  = ~(enq_btb_hit1 & enq_pred_taken1);
    wr_entry.pred_target1 = enq_pred_target1;
    wr_entry.pred_target2 = enq_pred_target2;
    wr_entry.pht_index1   = enq_pht_index1;
    wr_entry.pht_index2   = enq_pht_index2;
  end

  // Next-state logic for the pointers and the count. Reset and flush both return the queue
  // to its empty origin. Reset is also applied in the flop block.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // The depth is a power of two, so natural pointer overflow performs the wrap.
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (deq_fire) head_d = head_q + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_fire && !reset) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  assign head_entry = mem_q[head_q];

  // The head is gated to zero when the queue is empty, so stale storage never reaches decode.
  always_comb begin
    deq_pc           = '0;
    deq_instr1       = '0;
    deq_instr2       = '0;
    deq_pred_target1 = '0;
    deq_pred_target2 = '0;
    deq_pht_index1   = '0;
    deq_pht_index2   = '0;
    deq_slot_valid1  = 1'b0;
    deq_slot_valid2  = 1'b0;
    deq_pred_taken1  = 1'b0;
    deq_pred_taken2  = 1'b0;
    if (deq_valid) begin
      deq_pc           = head_entry.pc;
      deq_instr1       = head_entry.instr1;
      deq_instr2       = head_entry.instr2;
      deq_pred_target1 = head_entry.pred_target1;
      deq_pred_target2 = head_entry.pred_target2;
      deq_pht_index1   = head_entry.pht_index1;
      deq_pht_index2   = head_entry.pht_index2;
      deq_slot_valid1  = head_entry.slot_valid1;
      deq_slot_valid2  = head_entry.slot_valid2;
      deq_pred_taken1  = head_entry.pred_taken1;
      deq_pred_taken2  = head_entry.pred_taken2;
    end
  end

endmodule
